// File: rtl/srlatch_pulse_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : srlatch_pulse_ctrl
// Purpose  : Synchronous driver for the loop-control SR latch brick. Turns the
//            oscillator set request and the comparator reset request into clean
//            fixed-width s / r / rb pulses. Enforces a minimum on-time
//            (leading-edge blanking) and a minimum off-time. Checks the latch q
//            feedback at the end of every pulse and keeps a sticky fault flag.
// Ports    : clk        block clock
//            rst        asynchronous active-high reset (forces the latch clear)
//            CELV/CELG  supply / ground pins, no logic function
//            SUB        substrate pin, no logic function
//            en         loop enable, level
//            set_req    start-of-cycle request, level-sampled
//            reset_req  comparator trip, level-sampled
//            q_fb       latch q feedback
//            s          latch set pulse
//            r          latch reset pulse
//            rb         complement of r
//            fault      sticky feedback-mismatch flag
//            on_state   high while in SET or ON
// Revision : 1.0 - initial release
// ============================================================================
module srlatch_pulse_ctrl #(
  parameter int PW       = 2,
  parameter int TON_MIN  = 4,
  parameter int TOFF_MIN = 3,
  parameter int CW       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic CELV,
  input  logic CELG,
  input  logic SUB,
  input  logic en,
  input  logic set_req,
  input  logic reset_req,
  input  logic q_fb,
  output logic s,
  output logic r,
  output logic rb,
  output logic fault,
  output logic on_state
);

  localparam logic [1:0] ST_RST = 2'd0;
  localparam logic [1:0] ST_OFF = 2'd1;
  localparam logic [1:0] ST_SET = 2'd2;
  localparam logic [1:0] ST_ON  = 2'd3;

  // Counter load values: a state lasting N cycles loads N-1 and is done at 0.
  localparam logic [CW-1:0] PW_LD   = CW'(PW - 1);
  localparam logic [CW-1:0] TON_LD  = CW'(TON_MIN - 1);
  localparam logic [CW-1:0] TOFF_LD = CW'(TOFF_MIN - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          fault_nxt;
  logic          done;

  // Power pins carry no logic; gathered here so they are visibly consumed.
  logic unused_pins;
  assign unused_pins = CELV ^ CELG ^ SUB;

  assign done = (cnt == '0);

  always_comb begin
    state_nxt = state;
    fault_nxt = fault;
    cnt_nxt   = done ? cnt : (cnt - CW'(1));
    case (state)
      ST_OFF: begin
        // Disabling the loop while idle is the only in-band way to clear a fault.
        if (!en) begin
          fault_nxt = 1'b0;
        end
        // reset_req dominates a simultaneous set_req; a fault parks us here.
        if (done && en && set_req && !reset_req && !fault) begin
          state_nxt = ST_SET;
          cnt_nxt   = PW_LD;
        end
      end
      ST_SET: begin
        if (done) begin
          if (q_fb) begin
            state_nxt = ST_ON;
            cnt_nxt   = TON_LD;
          end else begin
            fault_nxt = 1'b1;
            state_nxt = ST_RST;
            cnt_nxt   = PW_LD;
          end
        end
      end
      ST_ON: begin
        // Blanking: reset_req and en are only honoured once the count expires.
        if (done && (reset_req || !en)) begin
          state_nxt = ST_RST;
          cnt_nxt   = PW_LD;
        end
      end
      default: begin // ST_RST
        if (done) begin
          if (q_fb) begin
            fault_nxt = 1'b1;
          end
          state_nxt = ST_OFF;
          cnt_nxt   = TOFF_LD;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet align
  // with the state they describe (set_req in OFF -> s on the very next edge).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RST;
      cnt      <= PW_LD;
      fault    <= 1'b0;
      s        <= 1'b0;
      r        <= 1'b1;
      rb       <= 1'b0;
      on_state <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      fault    <= fault_nxt;
      s        <= (state_nxt == ST_SET);
      r        <= (state_nxt == ST_RST);
      rb       <= (state_nxt != ST_RST);
      on_state <= (state_nxt == ST_SET) || (state_nxt == ST_ON);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_srlatch_pulse_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_srlatch_pulse_ctrl
// Purpose  : Randomized self-checking bench for srlatch_pulse_ctrl. A driver
//            applies random en / set_req / reset_req / rst, emulates the SR
//            latch brick on q_fb (with occasional stuck feedback), steps a
//            phase/elapsed-time reference model and queues the expected
//            outputs; a monitor pops and compares once per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_srlatch_pulse_ctrl;

  localparam int PW       = 2;
  localparam int TON_MIN  = 4;
  localparam int TOFF_MIN = 3;
  localparam int NCYC     = 4000;

  logic clk = 1'b0;
  logic rst, CELV, CELG, SUB, en, set_req, reset_req, q_fb;
  logic s, r, rb, fault, on_state;

  always #5 clk = ~clk;

  srlatch_pulse_ctrl #(.PW(PW), .TON_MIN(TON_MIN), .TOFF_MIN(TOFF_MIN), .CW(8)) dut (
    .clk(clk), .rst(rst), .CELV(CELV), .CELG(CELG), .SUB(SUB),
    .en(en), .set_req(set_req), .reset_req(reset_req), .q_fb(q_fb),
    .s(s), .r(r), .rb(rb), .fault(fault), .on_state(on_state)
  );

  // ---------------- reference model: phase + cycles spent in it ----------------
  typedef enum int {M_RST, M_OFF, M_SET, M_ON} mphase_t;
  mphase_t ph;
  int      age;     // cycles already completed in the current phase
  bit      mfault;

  function automatic int phase_len(mphase_t p);
    case (p)
      M_SET:   return PW;
      M_ON:    return TON_MIN;
      M_OFF:   return TOFF_MIN;
      default: return PW;
    endcase
  endfunction

  task automatic model_reset();
    ph = M_RST; age = 0; mfault = 0;
  endtask

  task automatic enter(mphase_t p);
    ph = p; age = 0;
  endtask

  // One clock edge with the inputs that were stable across it.
  task automatic model_edge(bit en_i, bit set_i, bit rq_i, bit q_i);
    bit expired;
    expired = (age + 1 >= phase_len(ph));
    if (!expired) age++;
    case (ph)
      M_OFF: begin
        if (!en_i) mfault = 0;
        else if (expired && set_i && !rq_i && !mfault) enter(M_SET);
      end
      M_SET: if (expired) begin
        if (q_i) enter(M_ON);
        else begin mfault = 1; enter(M_RST); end
      end
      M_ON: if (expired && (rq_i || !en_i)) enter(M_RST);
      default: if (expired) begin
        if (q_i) mfault = 1;
        enter(M_OFF);
      end
    endcase
  endtask

  // {s, r, rb, fault, on_state}
  function automatic logic [4:0] model_out();
    logic ms, mr;
    ms = (ph == M_SET);
    mr = (ph == M_RST);
    return {ms, mr, ~mr, mfault, (ph == M_SET) || (ph == M_ON)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [4:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;

  initial begin : monitor
    logic [4:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        exp_v = sb.pop_front();
        act_v = {s, r, rb, fault, on_state};
        n_cmp++;
        if (act_v !== exp_v) begin
          n_err++;
          if (n_err <= 20)
            $display("FAIL outputs{s,r,rb,fault,on} t=%0t actual=%b required=%b", $time, act_v, exp_v);
        end
      end
    end
  end

  // ---------------- driver ----------------
  initial begin : driver
    bit latch_q, stuck, stuck_val, s_prev, r_prev;
    rst = 1'b1; CELV = 1'b1; CELG = 1'b0; SUB = 1'b0;
    en = 1'b0; set_req = 1'b0; reset_req = 1'b0; q_fb = 1'b0;
    latch_q = 0; stuck = 0; stuck_val = 0;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      s_prev = s;
      r_prev = r;
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge(en, set_req, reset_req, q_fb);
      // SR latch brick responds to the pulses present before this edge.
      if (s_prev)      latch_q = 1;
      else if (r_prev) latch_q = 0;
      #1;
      if (cyc < 3)                                      rst = 1'b1;
      else if (!rst && cyc > 20 && $urandom_range(0, 249) == 0) rst = 1'b1;
      else                                              rst = 1'b0;
      if (rst) model_reset();
      en        = ($urandom_range(0, 15) != 0);
      set_req   = ($urandom_range(0, 1) == 1);
      reset_req = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 59) == 0) begin
        stuck     = ~stuck;
        stuck_val = 1'($urandom_range(0, 1));
      end
      q_fb = stuck ? stuck_val : latch_q;
      sb.push_back(model_out());
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain actual=%0d left required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
